// File: rtl/stream_demux_if.sv
// -----------------------------------------------------------------------------
// stream_demux_if
//   Bundle of the handshake and data signals around the 1:2 stream
//   demultiplexer. One instance connects the upstream producer, both
//   downstream consumers and the counter controls to the demux.
//
//   Parameters
//     WIDTH  data word width in bits
//     CNT_W  width of the per-output delivered-word counters
//
//   Signals
//     in_data  / in_sel / in_valid / in_ready  : upstream stream
//     a_data   / a_valid / a_ready             : output A stream
//     b_data   / b_valid / b_ready             : output B stream
//     cnt_clr                                  : synchronous counter clear
//     a_count  / b_count                       : words delivered per output
//
//   Modports
//     slave  : the demux itself (consumes in_*, produces a_* / b_*)
//     master : the surrounding environment (producer + both consumers)
// -----------------------------------------------------------------------------
interface stream_demux_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;

  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  logic             cnt_clr;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  modport slave (
    input  in_data,
    input  in_sel,
    input  in_valid,
    output in_ready,
    output a_data,
    output a_valid,
    input  a_ready,
    output b_data,
    output b_valid,
    input  b_ready,
    input  cnt_clr,
    output a_count,
    output b_count
  );

  modport master (
    output in_data,
    output in_sel,
    output in_valid,
    input  in_ready,
    input  a_data,
    input  a_valid,
    output a_ready,
    input  b_data,
    input  b_valid,
    output b_ready,
    output cnt_clr,
    input  a_count,
    input  b_count
  );

endinterface : stream_demux_if

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   1:2 demultiplexer for datapath words. Each word offered on the input
//   stream is steered to output A (in_sel = 0) or output B (in_sel = 1).
//   Every output owns a one-entry registered slot, so a stalled consumer only
//   back-pressures words aimed at its own slot; the other path keeps flowing.
//   A slot can drain and reload in the same cycle, giving one word per cycle
//   per output. Load latency is one clock.
//
//   Ports
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset; empties both slots, zeroes data
//              and counters (held words are discarded, never replayed)
//     bus    : stream_demux_if.slave carrying
//                in_data/in_sel/in_valid -> in_ready (combinational)
//                a_data/a_valid <- a_ready, b_data/b_valid <- b_ready
//                cnt_clr -> a_count/b_count
//
//   Optional feature (macro STREAM_DEMUX_COUNT_EN)
//     Defined     : a_count/b_count count output handshakes, wrap modulo
//                   2^CNT_W; cnt_clr zeroes both and beats an increment.
//     Not defined : no counter registers; counts read 0; cnt_clr ignored.
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_demux_if.slave   bus
);

  // Per-output slot state; encoding doubles as the valid flag.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      a_state_r;
  slot_state_e      a_state_next_s;
  slot_state_e      b_state_r;
  slot_state_e      b_state_next_s;

  logic [WIDTH-1:0] a_data_r;
  logic [WIDTH-1:0] b_data_r;

  logic             a_valid_s;
  logic             b_valid_s;
  logic             a_room_s;
  logic             b_room_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             load_a_s;
  logic             load_b_s;
  logic             drain_a_s;
  logic             drain_b_s;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign a_valid_s = (a_state_r == ST_FULL);
  assign b_valid_s = (b_state_r == ST_FULL);

  // A slot can take a word if it is empty or is being drained this cycle.
  assign a_room_s  = !a_valid_s || bus.a_ready;
  assign b_room_s  = !b_valid_s || bus.b_ready;

  // Ready looks only at the selected slot, so a stall on the other output
  // never blocks this word.
  assign in_ready_s = bus.in_sel ? b_room_s : a_room_s;
  assign accept_s   = bus.in_valid && in_ready_s;

  assign load_a_s  = accept_s && !bus.in_sel;
  assign load_b_s  = accept_s &&  bus.in_sel;
  assign drain_a_s = a_valid_s && bus.a_ready;
  assign drain_b_s = b_valid_s && bus.b_ready;

  // ---------------------------------------------------------------------------
  // Output A slot
  // ---------------------------------------------------------------------------

  // Next-state logic for the output A slot.
  always_comb begin
    a_state_next_s = a_state_r;
    case (a_state_r)
      ST_EMPTY: begin
        if (load_a_s) begin
          a_state_next_s = ST_FULL;
        end else begin
          a_state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Load wins over drain: drain+load keeps the slot full.
        if (load_a_s) begin
          a_state_next_s = ST_FULL;
        end else if (drain_a_s) begin
          a_state_next_s = ST_EMPTY;
        end else begin
          a_state_next_s = ST_FULL;
        end
      end
      default: begin
        a_state_next_s = ST_EMPTY;
      end
    endcase
  end

  // State and data registers for the output A slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state_r <= ST_EMPTY;
      a_data_r  <= {WIDTH{1'b0}};
    end else begin
      a_state_r <= a_state_next_s;
      if (load_a_s) begin
        a_data_r <= bus.in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output B slot
  // ---------------------------------------------------------------------------

  // Next-state logic for the output B slot.
  always_comb begin
    b_state_next_s = b_state_r;
    case (b_state_r)
      ST_EMPTY: begin
        if (load_b_s) begin
          b_state_next_s = ST_FULL;
        end else begin
          b_state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_b_s) begin
          b_state_next_s = ST_FULL;
        end else if (drain_b_s) begin
          b_state_next_s = ST_EMPTY;
        end else begin
          b_state_next_s = ST_FULL;
        end
      end
      default: begin
        b_state_next_s = ST_EMPTY;
      end
    endcase
  end

  // State and data registers for the output B slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state_r <= ST_EMPTY;
      b_data_r  <= {WIDTH{1'b0}};
    end else begin
      b_state_r <= b_state_next_s;
      if (load_b_s) begin
        b_data_r <= bus.in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delivered-word counters
  // ---------------------------------------------------------------------------
`ifdef STREAM_DEMUX_COUNT_EN

  logic [CNT_W-1:0] a_count_r;
  logic [CNT_W-1:0] b_count_r;

  // Output A handshake counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count_r <= {CNT_W{1'b0}};
    end else if (bus.cnt_clr) begin
      a_count_r <= {CNT_W{1'b0}};
    end else if (drain_a_s) begin
      a_count_r <= a_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output B handshake counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_count_r <= {CNT_W{1'b0}};
    end else if (bus.cnt_clr) begin
      b_count_r <= {CNT_W{1'b0}};
    end else if (drain_b_s) begin
      b_count_r <= b_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.a_count = a_count_r;
  assign bus.b_count = b_count_r;

`else

  // Counters not built: the clear input has no function here.
  logic cnt_clr_unused_s;
  assign cnt_clr_unused_s = bus.cnt_clr;

  assign bus.a_count = {CNT_W{1'b0}};
  assign bus.b_count = {CNT_W{1'b0}};

`endif

  // ---------------------------------------------------------------------------
  // Outputs: data and valid come straight from the slot registers.
  // ---------------------------------------------------------------------------
  assign bus.in_ready = in_ready_s;
  assign bus.a_data   = a_data_r;
  assign bus.a_valid  = a_valid_s;
  assign bus.b_data   = b_data_r;
  assign bus.b_valid  = b_valid_s;

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Directed self-checking bench for stream_demux. Inputs change 1 ns after
//   the rising edge; outputs are checked 1 ns after the edge (registered) or
//   1 ns after an input change (combinational in_ready). Counter expectations
//   follow STREAM_DEMUX_COUNT_EN (zero when the feature is not built).
// -----------------------------------------------------------------------------
module tb_stream_demux;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  stream_demux_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  stream_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected counter value: the given count when counters exist, else 0.
  function automatic logic [31:0] cexp(input int n);
`ifdef STREAM_DEMUX_COUNT_EN
    return 32'(n % 256);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.in_data  = 16'h0000;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.cnt_clr  = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_a_valid", 32'(bus.a_valid), 32'h0);
    check("rst_b_valid", 32'(bus.b_valid), 32'h0);
    check("rst_a_data",  32'(bus.a_data),  32'h0000);
    check("rst_b_data",  32'(bus.b_data),  32'h0000);
    check("rst_a_count", 32'(bus.a_count), 32'h0);
    check("rst_b_count", 32'(bus.b_count), 32'h0);
    check("rst_ready_sel0", 32'(bus.in_ready), 32'h1);
    bus.in_sel = 1'b1;
    #1 check("rst_ready_sel1", 32'(bus.in_ready), 32'h1);
    tick();

    // Single route to A with A stalled
    bus.in_data = 16'h1234; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("single_a_valid", 32'(bus.a_valid), 32'h1);
    check("single_a_data",  32'(bus.a_data),  32'h1234);
    check("single_b_valid", 32'(bus.b_valid), 32'h0);
    tick();
    check("single_hold_valid", 32'(bus.a_valid), 32'h1);
    check("single_hold_data",  32'(bus.a_data),  32'h1234);
    bus.a_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0;
    check("single_drained", 32'(bus.a_valid), 32'h0);
    check("single_a_count", 32'(bus.a_count), cexp(1));

    // Stall isolation
    bus.in_data = 16'hAAAA; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_data = 16'h5555; bus.in_sel = 1'b1;
    #1 check("iso_ready_b", 32'(bus.in_ready), 32'h1);
    tick();
    check("iso_b_valid", 32'(bus.b_valid), 32'h1);
    check("iso_b_data",  32'(bus.b_data),  32'h5555);
    check("iso_a_data",  32'(bus.a_data),  32'hAAAA);
    bus.in_data = 16'h0F0F; bus.in_sel = 1'b0;
    #1 check("iso_ready_a_stall", 32'(bus.in_ready), 32'h0);
    bus.b_ready = 1'b1;
    #1 check("iso_ready_ignores_b", 32'(bus.in_ready), 32'h0);
    bus.b_ready = 1'b0;
    tick();
    check("iso_a_hold_data",  32'(bus.a_data),  32'hAAAA);
    check("iso_a_hold_valid", 32'(bus.a_valid), 32'h1);
    check("iso_b_hold_data",  32'(bus.b_data),  32'h5555);
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b1;
    #1 check("iso_ready_b_full", 32'(bus.in_ready), 32'h0);
    bus.b_ready = 1'b1;
    #1 check("iso_ready_b_drain", 32'(bus.in_ready), 32'h1);
    // Both outputs drain in the same cycle
    bus.a_ready = 1'b1;
    tick();
    bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    check("dual_drain_a", 32'(bus.a_valid), 32'h0);
    check("dual_drain_b", 32'(bus.b_valid), 32'h0);
    check("dual_a_count", 32'(bus.a_count), cexp(2));
    check("dual_b_count", 32'(bus.b_count), cexp(1));

    // Back-to-back stream into A, drain and reload each cycle
    bus.a_ready = 1'b1; bus.in_sel = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.in_data  = 16'(i);
      bus.in_valid = 1'b1;
      #1 check("b2b_ready", 32'(bus.in_ready), 32'h1);
      tick();
      check("b2b_data",  32'(bus.a_data),  32'(i));
      check("b2b_valid", 32'(bus.a_valid), 32'h1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("b2b_empty",   32'(bus.a_valid), 32'h0);
    check("b2b_a_count", 32'(bus.a_count), cexp(10));
    bus.a_ready = 1'b0;

    // Clear with a concurrent B handshake: clear wins
    bus.in_data = 16'hBEEF; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.b_ready = 1'b1; bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0; bus.b_ready = 1'b0;
    check("clr_b_count", 32'(bus.b_count), 32'h0);
    check("clr_a_count", 32'(bus.a_count), 32'h0);
    check("clr_b_valid", 32'(bus.b_valid), 32'h0);

    // Three B handshakes
    bus.b_ready = 1'b1; bus.in_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data  = 16'(16'h0B00 + i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.b_ready = 1'b0;
    check("three_b_count", 32'(bus.b_count), cexp(3));
    check("three_b_data",  32'(bus.b_data),  32'h0B02);

    // 256 A handshakes wrap the A counter
    bus.a_ready = 1'b1; bus.in_sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.in_data  = 16'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check("wrap_a_count_255", 32'(bus.a_count), cexp(255));
    tick();
    bus.a_ready = 1'b0;
    check("wrap_a_count_0", 32'(bus.a_count), 32'h0);
    check("wrap_b_count",   32'(bus.b_count), cexp(3));

    // Async reset mid-transfer
    bus.in_data = 16'h1111; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_data = 16'h2222; bus.in_sel = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_a_valid", 32'(bus.a_valid), 32'h1);
    check("pre_rst_b_valid", 32'(bus.b_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_a_valid", 32'(bus.a_valid), 32'h0);
    check("async_b_valid", 32'(bus.b_valid), 32'h0);
    check("async_a_data",  32'(bus.a_data),  32'h0000);
    check("async_b_count", 32'(bus.b_count), 32'h0);
    check("async_a_count", 32'(bus.a_count), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    tick();
    check("no_replay_a", 32'(bus.a_valid), 32'h0);
    check("no_replay_b", 32'(bus.b_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stream_demux

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1:2 demultiplexer for 16-bit datapath words: the steering counterpart of the 2:1 source-select mux.
- Accepts one word per cycle on a valid/ready input stream.
- Routes each word to output A or B according to a per-word select bit.
- Each output holds the word in its own one-entry registered stage until the consumer takes it, so a stalled destination never corrupts the other path.

Parameters:
- WIDTH, 16, data word width in bits.
- CNT_W, 8, width of the per-output word counters (optional feature only).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  destination select; 0 = output A, 1 = output B; qualified by in_valid.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- a_data  output  WIDTH  output A word.
- a_valid  output  1  output A holds a word.
- a_ready  input  1  consumer A takes the word this cycle.
- b_data  output  WIDTH  output B word.
- b_valid  output  1  output B holds a word.
- b_ready  input  1  consumer B takes the word this cycle.
- cnt_clr  input  1  synchronous clear of both counters.
- a_count  output  CNT_W  words delivered on A.
- b_count  output  CNT_W  words delivered on B.

Behaviour:
- Reset: rst_n low asynchronously forces a_valid = b_valid = 0, a_data = b_data = 0, a_count = b_count = 0.
- Reset mid-transfer: any held word is discarded; nothing is replayed after reset.
- in_ready is combinational:
  - in_sel = 0: in_ready = !a_valid || a_ready.
  - in_sel = 1: in_ready = !b_valid || b_ready.
- in_ready does not depend on the non-selected output.
- Accept = in_valid && in_ready.
- On accept, the selected output's data register loads in_data and its valid is set on the next clock edge. Latency is 1 cycle.
- Output handshake = x_valid && x_ready. With no simultaneous load into that output, x_valid clears next edge.
- Simultaneous drain and load on the same output: the new word loads and x_valid stays 1. This gives full throughput of 1 word/cycle per output.
- While x_valid = 1 and x_ready = 0, x_data and x_valid hold stable.
- The non-selected output never changes on an accept.
- A and B drain independently; both may complete a handshake in the same cycle.
- in_valid = 0: no state changes; in_sel and in_data are ignored.
- in_valid = 1 with in_ready = 0: the word is not taken; the source must hold it.
- Per-output state machine, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load, or on stall.

Optional Feature:
- Macro: STREAM_DEMUX_COUNT_EN.
- Defined:
  - a_count increments by 1 on each A output handshake; b_count likewise on each B handshake.
  - Counters wrap modulo 2^CNT_W (255 -> 0).
  - cnt_clr = 1 zeroes both counters next edge and takes priority over a same-cycle increment.
- Not defined:
  - No counter registers are built.
  - a_count and b_count are tied to 0.
  - cnt_clr is ignored.

Test Plan:
- Reset: hold rst_n = 0, then release -> a_valid = b_valid = 0, a_data = b_data = 0x0000, in_ready = 1 for either in_sel.
- Single route: in_data = 0x1234, in_sel = 0, in_valid = 1 for 1 cycle, a_ready = 0 -> next cycle a_valid = 1, a_data = 0x1234, b_valid = 0. a_data holds 0x1234 until a_ready = 1, then a_valid = 0.
- Stall isolation: A full with 0xAAAA and a_ready = 0; present 0x5555 with in_sel = 1 -> accepted, b_data = 0x5555. Then present 0x0F0F with in_sel = 0 -> in_ready = 0 and a_data stays 0xAAAA.
- Back-to-back: a_ready = 1, stream 0x0001..0x0008 to A on consecutive cycles -> in_ready = 1 every cycle; A delivers 0x0001..0x0008 in order, one per cycle, 1-cycle latency.
- Async reset mid-transfer: A and B both full, assert rst_n low between clock edges -> both valids drop immediately without a clock edge; counters read 0.
- Counter (STREAM_DEMUX_COUNT_EN):
  - 256 A handshakes -> a_count wraps to 0.
  - 3 B handshakes -> b_count = 3.
  - cnt_clr with a concurrent B handshake -> b_count = 0.
